// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32I core.
// Keeps one imem request in flight, parks a returned word while stalled, squashes on Flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] Branch_Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic [4:0]  IF_ID_Rs1,
  output logic [4:0]  IF_ID_Rs2
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        kill, kill_n;
  logic [31:0] buf_instr, buf_n;
  logic [31:0] id_pc_n, id_instr_n;
  logic        id_vld_n;
  logic        take;
  logic [31:0] take_word;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign IF_ID_Rs1 = IF_ID_Instr[19:15];
  assign IF_ID_Rs2 = IF_ID_Instr[24:20];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      buf_instr   <= '0;
      IF_ID_PC    <= '0;
      IF_ID_Instr <= NOP_INSTR;
      IF_ID_Valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      kill        <= kill_n;
      buf_instr   <= buf_n;
      IF_ID_PC    <= id_pc_n;
      IF_ID_Instr <= id_instr_n;
      IF_ID_Valid <= id_vld_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    kill_n     = kill;
    buf_n      = buf_instr;
    id_pc_n    = IF_ID_PC;
    id_instr_n = IF_ID_Instr;
    id_vld_n   = IF_ID_Valid;
    take       = 1'b0;
    take_word  = buf_instr;

    if (Flush && state != S_IDLE) begin
      // A request already on the bus cannot be recalled; mark its response as dead.
      pc_n       = Branch_Target;
      id_pc_n    = '0;
      id_instr_n = NOP_INSTR;
      id_vld_n   = 1'b0;
      buf_n      = '0;
      case (state)
        S_REQ: begin
          kill_n  = 1'b1;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            kill_n  = 1'b1;
          end
        end
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ:  state_n = S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            if (kill) begin
              kill_n  = 1'b0;
              state_n = S_REQ;
            end else if (Stall) begin
              buf_n   = imem_rdata;
              state_n = S_HOLD;
            end else begin
              take      = 1'b1;
              take_word = imem_rdata;
              state_n   = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            take    = 1'b1;
            state_n = S_REQ;
          end
        end
        default: state_n = S_IDLE;
      endcase

      if (take) begin
        id_pc_n    = pc;
        id_instr_n = take_word;
        id_vld_n   = 1'b1;
        pc_n       = pc + 32'd4;
      end else if (!Stall) begin
        // Nothing new this cycle: bubble, keeping the last PC for visibility.
        id_instr_n = NOP_INSTR;
        id_vld_n   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory responder/stimulus side feeds an
// expected-instruction queue; a separate monitor checks IF/ID every cycle.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall, Flush;
  logic [31:0] Branch_Target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] IF_ID_PC, IF_ID_Instr;
  logic        IF_ID_Valid;
  logic [4:0]  IF_ID_Rs1, IF_ID_Rs2;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush),
    .Branch_Target(Branch_Target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .IF_ID_PC(IF_ID_PC),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_Valid(IF_ID_Valid),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;
  bit   mon_en = 1'b0;

  // responder / architectural model state
  bit          out_busy, out_kill, armed;
  int          out_cnt, idle_cnt;
  logic [31:0] out_addr, exp_fetch;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset();
    chk(imem_req == 1'b0,       "rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk(IF_ID_PC == 32'd0,      "rst_pc",       IF_ID_PC, 32'd0);
    chk(IF_ID_Instr == NOP_INSTR, "rst_instr",  IF_ID_Instr, NOP_INSTR);
    chk(IF_ID_Valid == 1'b0,    "rst_valid",    {31'd0, IF_ID_Valid}, 32'd0);
    chk(IF_ID_Rs1 == 5'd0 && IF_ID_Rs2 == 5'd0, "rst_rs", {22'd0, IF_ID_Rs2, IF_ID_Rs1}, 32'd0);
  endtask

  task automatic model_clear();
    q.delete();
    out_busy  = 1'b0;
    out_kill  = 1'b0;
    armed     = 1'b0;
    out_cnt   = 0;
    idle_cnt  = 0;
    exp_fetch = RESET_PC;
  endtask

  // Reset asserted mid-cycle; released on a negedge with a stale response driven
  // into the first post-reset cycle, which the DUT must ignore.
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset();
    model_clear();
    Stall = 1'b0; Flush = 1'b0; imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    mon_en     = 1'b1;
  endtask

  // stimulus + memory responder
  initial begin
    bit          rv, req_now, st, fl, rst_pending;
    logic [31:0] bt, r;
    rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0; Branch_Target = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    rst_pending = 1'b0;
    #2;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc == 1300 || cyc == 2600) rst_pending = 1'b1;
      if (rst_pending && out_busy && out_cnt > 1) begin
        rst_pending = 1'b0;
        do_reset();
        continue;
      end
      rv = 1'b0;
      if (out_busy) begin
        out_cnt--;
        if (out_cnt == 0) rv = 1'b1;
      end
      req_now = imem_req;
      if (req_now) begin
        chk(!out_busy, "one_outstanding", {31'd0, out_busy}, 32'd0);
        chk(imem_addr == exp_fetch, "fetch_addr", imem_addr, exp_fetch);
      end
      if (req_now || out_busy) idle_cnt = 0;
      else idle_cnt++;
      if (idle_cnt > 40) begin
        chk(1'b0, "liveness", 32'd0, 32'd1);
        idle_cnt = 0;
      end

      st = ($urandom_range(0, 9) < 3);
      fl = armed && ($urandom_range(0, 99) < 8);
      r  = $urandom;
      case ($urandom_range(0, 5))
        0: bt = 32'hFFFF_FFF8;
        1: bt = 32'hFFFF_FFFC;
        2: bt = 32'h0000_0100;
        3: bt = r;
        default: bt = {r[31:2], 2'b00};
      endcase

      if (rv) begin
        if (!(out_kill || fl)) begin
          q.push_back('{pc: out_addr, instr: mem_word(out_addr)});
          exp_fetch = out_addr + 32'd4;
        end
        out_busy = 1'b0;
      end
      if (fl) begin
        q.delete();
        exp_fetch = bt;
        if (out_busy) out_kill = 1'b1;
      end
      if (req_now) begin
        out_busy = 1'b1;
        out_addr = imem_addr;
        out_kill = fl;
        out_cnt  = $urandom_range(1, 3);
        armed    = 1'b1;
      end

      Stall         = st;
      Flush         = fl;
      Branch_Target = bt;
      imem_valid    = rv;
      imem_rdata    = rv ? mem_word(out_addr) : $urandom;
    end
    Stall = 1'b0; Flush = 1'b0; imem_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // monitor: judges IF/ID after every edge from the inputs sampled on that edge
  initial begin
    logic [31:0] prev_pc, prev_instr;
    logic        prev_vld, s, f;
    exp_t        e;
    prev_pc = '0; prev_instr = NOP_INSTR; prev_vld = 1'b0;
    forever begin
      @(posedge clk);
      s = Stall;
      f = Flush;
      #1;
      if (mon_en) begin
        if (f) begin
          chk(!IF_ID_Valid && IF_ID_Instr == NOP_INSTR && IF_ID_PC == 32'd0,
              "flush_bubble", IF_ID_Instr, NOP_INSTR);
        end else if (s) begin
          chk(IF_ID_PC == prev_pc && IF_ID_Instr == prev_instr && IF_ID_Valid == prev_vld,
              "stall_hold", IF_ID_Instr, prev_instr);
        end else if (q.size() > 0) begin
          e = q.pop_front();
          chk(IF_ID_Valid == 1'b1, "deliver_valid", {31'd0, IF_ID_Valid}, 32'd1);
          chk(IF_ID_PC == e.pc, "deliver_pc", IF_ID_PC, e.pc);
          chk(IF_ID_Instr == e.instr && IF_ID_Rs1 == e.instr[19:15] && IF_ID_Rs2 == e.instr[24:20],
              "deliver_instr", IF_ID_Instr, e.instr);
        end else begin
          chk(!IF_ID_Valid && IF_ID_Instr == NOP_INSTR && IF_ID_PC == prev_pc,
              "bubble", IF_ID_Instr, NOP_INSTR);
        end
      end
      prev_pc    = IF_ID_PC;
      prev_instr = IF_ID_Instr;
      prev_vld   = IF_ID_Valid;
    end
  end

endmodule
